// File: rtl/lsu.sv
// Load/store unit sitting after the execute-stage ALU.
// Runs one data-memory transaction per accepted request over a req/gnt/rvalid
// bus, formats store lanes and load writeback data, and reports misaligned,
// illegal-width and timed-out accesses through resp_err.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // Last counter value that still allows the access to continue; a grant in
    // that final cycle pushes the count past it, so the compare uses >=.
    localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  addr_lo;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [4:0]  rd_q;
    logic [15:0] tcnt;

    logic        illegal;
    logic        misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    // Classify the incoming request: width codes with no encoding are illegal,
    // and illegal wins over misaligned because the width is then meaningless.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (req_we)
            illegal = req_funct3[2] || (req_funct3 == 3'b011);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111);
        case (req_funct3)
            3'b001, 3'b101: misaligned = req_addr[0];
            3'b010:         misaligned = (req_addr[1:0] != 2'b00);
            default:        misaligned = 1'b0;
        endcase
    end

    // Replicate store data across all lanes so the strobes alone pick the bytes.
    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = req_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        ld_byte   = mem_rdata[{addr_lo, 3'b000} +: 8];
        ld_half   = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Transaction FSM; every output is registered and changes only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'b0000;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_rd    <= 5'd0;
            resp_err   <= 2'b00;
            tcnt       <= 16'd0;
            addr_lo    <= 2'b00;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            rd_q       <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo   <= req_addr[1:0];
                        funct3_q  <= req_funct3;
                        we_q      <= req_we;
                        rd_q      <= req_rd;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (illegal || misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= illegal ? 2'b10 : 2'b01;
                            resp_rdata <= 32'h0;
                            resp_rd    <= req_rd;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= st_wdata;
                            mem_wstrb <= req_we ? st_wstrb : 4'b0000;
                            tcnt      <= 16'd0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        tcnt    <= tcnt + 16'd1;
                        if (we_q) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 2'b00;
                            resp_rdata <= 32'h0;
                            resp_rd    <= rd_q;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (tcnt >= TLAST) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b11;
                        resp_rdata <= 32'h0;
                        resp_rd    <= rd_q;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b00;
                        resp_rdata <= load_data;
                        resp_rd    <= rd_q;
                    end else if (tcnt >= TLAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b11;
                        resp_rdata <= 32'h0;
                        resp_rd    <= rd_q;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
